hub75_fb_writer: RTL and testbench

//  Producer side of the hub75 frame buffer write interface (fbw_*, frame_swap/rdy, fb_loaded).

---
 rtl/hub75_fb_writer_pkg.sv | 12 +
 rtl/hub75_fb_writer.sv | 201 ++++++++++++++++++++
 tb/tb_hub75_fb_writer.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_fb_writer_pkg.sv
// Shared types for the hub75 frame buffer writer.
package hub75_fb_writer_pkg;

    // Writer sequencing: fill a line, commit it, flush the frame, wait for the swap.
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ROW   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_SWAP  = 2'd3
    } fbw_state_t;

endpackage

// File: rtl/hub75_fb_writer.sv
// Producer side of the hub75 frame buffer write interface. Takes an SOF-marked
// raster pixel stream, writes each line into the line buffer, commits rows to
// the frame buffer and requests a front/back swap once a full frame is stored.
module hub75_fb_writer
    import hub75_fb_writer_pkg::*;
#(
    parameter int N_BANKS     = 2,
    parameter int N_ROWS      = 32,
    parameter int N_COLS      = 64,
    parameter int BITDEPTH    = 24,
    parameter int LOG_N_BANKS = $clog2(N_BANKS),
    parameter int LOG_N_ROWS  = $clog2(N_ROWS),
    parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BITDEPTH-1:0]    in_data,
    input  logic                   in_sof,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [LOG_N_BANKS-1:0] fbw_bank_addr,
    output logic [LOG_N_ROWS-1:0]  fbw_row_addr,
    output logic                   fbw_row_store,
    input  logic                   fbw_row_rdy,
    output logic                   fbw_row_swap,
    output logic [BITDEPTH-1:0]    fbw_data,
    output logic [LOG_N_COLS-1:0]  fbw_col_addr,
    output logic                   fbw_wren,
    output logic                   frame_swap,
    input  logic                   frame_rdy,
    output logic                   fb_loaded,
    output logic                   stat_frame,
    output logic                   stat_resync
);

    // Line index = {bank, row}; the bank sits in the MSBs.
    localparam int LW = LOG_N_BANKS + LOG_N_ROWS;
    localparam logic [LW-1:0]         LAST_LINE = LW'(N_BANKS * N_ROWS - 1);
    localparam logic [LOG_N_COLS-1:0] LAST_COL  = LOG_N_COLS'(N_COLS - 1);

    fbw_state_t            state, state_next;
    logic [LOG_N_COLS-1:0] col, col_next;
    logic [LW-1:0]         line, line_next;
    logic [LW-1:0]         store_line, store_line_next;
    logic                  guard, guard_next;
    logic                  synced, synced_next;
    logic                  armed;
    logic                  accept;

    logic                  wren_next;
    logic [LOG_N_COLS-1:0] wcol_next;
    logic [BITDEPTH-1:0]   wdata_next;
    logic                  row_pulse, row_pulse_next;
    logic                  frame_pulse, frame_pulse_next;
    logic                  loaded_next;
    logic                  resync_next;

    // armed keeps in_ready low for the first cycle out of reset.
    assign in_ready = armed && (state == ST_FILL);
    assign accept   = in_valid && in_ready;

    // Row store and line buffer swap always fire together; frame swap and its stat pulse likewise.
    assign fbw_row_store = row_pulse;
    assign fbw_row_swap  = row_pulse;
    assign frame_swap    = frame_pulse;
    assign stat_frame    = frame_pulse;

    // Address of the committed row is latched when the store is issued, so it stays put
    // while the line counter has already moved on.
    assign fbw_bank_addr = store_line[LW-1 -: LOG_N_BANKS];
    assign fbw_row_addr  = store_line[LOG_N_ROWS-1:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, counter updates and next values of all registered outputs.
    always_comb begin
        state_next       = state;
        col_next         = col;
        line_next        = line;
        store_line_next  = store_line;
        guard_next       = guard;
        synced_next      = synced;
        wren_next        = 1'b0;
        wcol_next        = fbw_col_addr;
        wdata_next       = fbw_data;
        row_pulse_next   = 1'b0;
        frame_pulse_next = 1'b0;
        loaded_next      = fb_loaded;
        resync_next      = 1'b0;

        case (state)
            ST_FILL: begin
                if (accept) begin
                    if (in_sof) begin
                        // SOF restarts the raster; an SOF off (0,0) throws away the partial line/frame.
                        wren_next   = 1'b1;
                        wcol_next   = '0;
                        wdata_next  = in_data;
                        synced_next = 1'b1;
                        resync_next = (line != '0) || (col != '0);
                        line_next   = '0;
                        col_next    = LOG_N_COLS'(1);
                    end else if (synced) begin
                        wren_next  = 1'b1;
                        wcol_next  = col;
                        wdata_next = in_data;
                        if (col == LAST_COL) begin
                            col_next   = '0;
                            state_next = ST_ROW;
                        end else begin
                            col_next = col + 1'b1;
                        end
                    end
                    // Not yet synced: the pixel is consumed and dropped.
                end
            end

            ST_ROW: begin
                if (fbw_row_rdy) begin
                    row_pulse_next  = 1'b1;
                    store_line_next = line;
                    if (line == LAST_LINE) begin
                        guard_next = 1'b1;
                        state_next = ST_FLUSH;
                    end else begin
                        line_next  = line + 1'b1;
                        state_next = ST_FILL;
                    end
                end
            end

            ST_FLUSH: begin
                // The row-store engine may still report idle for the store just issued;
                // skip one cycle before trusting fbw_row_rdy.
                if (guard) begin
                    guard_next = 1'b0;
                end else if (fbw_row_rdy) begin
                    frame_pulse_next = 1'b1;
                    loaded_next      = 1'b1;
                    guard_next       = 1'b1;
                    state_next       = ST_SWAP;
                end
            end

            ST_SWAP: begin
                // Same one-cycle guard for frame_rdy after the swap request.
                if (guard) begin
                    guard_next = 1'b0;
                end else if (frame_rdy) begin
                    line_next  = '0;
                    state_next = ST_FILL;
                end
            end

            default: begin
                state_next = ST_FILL;
            end
        endcase
    end

    // Counters, flags and registered interface outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col          <= '0;
            line         <= '0;
            store_line   <= '0;
            guard        <= 1'b0;
            synced       <= 1'b0;
            armed        <= 1'b0;
            fbw_wren     <= 1'b0;
            fbw_col_addr <= '0;
            fbw_data     <= '0;
            row_pulse    <= 1'b0;
            frame_pulse  <= 1'b0;
            fb_loaded    <= 1'b0;
            stat_resync  <= 1'b0;
        end else begin
            col          <= col_next;
            line         <= line_next;
            store_line   <= store_line_next;
            guard        <= guard_next;
            synced       <= synced_next;
            armed        <= 1'b1;
            fbw_wren     <= wren_next;
            fbw_col_addr <= wcol_next;
            fbw_data     <= wdata_next;
            row_pulse    <= row_pulse_next;
            frame_pulse  <= frame_pulse_next;
            fb_loaded    <= loaded_next;
            stat_resync  <= resync_next;
        end
    end

endmodule

// File: tb/tb_hub75_fb_writer.sv
// Bench for hub75_fb_writer on a reduced 2 bank x 2 row x 4 column geometry.
module tb_hub75_fb_writer;

    localparam int NB    = 2;
    localparam int NR    = 2;
    localparam int NC    = 4;
    localparam int BD    = 24;
    localparam int LINES = NB * NR;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [BD-1:0] in_data = '0;
    logic          in_sof = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [0:0]    fbw_bank_addr;
    logic [0:0]    fbw_row_addr;
    logic          fbw_row_store;
    logic          fbw_row_rdy = 1'b1;
    logic          fbw_row_swap;
    logic [BD-1:0] fbw_data;
    logic [1:0]    fbw_col_addr;
    logic          fbw_wren;
    logic          frame_swap;
    logic          frame_rdy = 1'b1;
    logic          fb_loaded;
    logic          stat_frame;
    logic          stat_resync;

    hub75_fb_writer #(
        .N_BANKS (NB),
        .N_ROWS  (NR),
        .N_COLS  (NC),
        .BITDEPTH(BD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_sof       (in_sof),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fbw_bank_addr(fbw_bank_addr),
        .fbw_row_addr (fbw_row_addr),
        .fbw_row_store(fbw_row_store),
        .fbw_row_rdy  (fbw_row_rdy),
        .fbw_row_swap (fbw_row_swap),
        .fbw_data     (fbw_data),
        .fbw_col_addr (fbw_col_addr),
        .fbw_wren     (fbw_wren),
        .frame_swap   (frame_swap),
        .frame_rdy    (frame_rdy),
        .fb_loaded    (fb_loaded),
        .stat_frame   (stat_frame),
        .stat_resync  (stat_resync)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Event monitor: logs writes and stores, counts pulses.
    int wren_cnt = 0, store_cnt = 0, fswap_cnt = 0, sframe_cnt = 0, resync_cnt = 0, pair_err = 0;
    logic [25:0] wr_log[$];
    logic [1:0]  st_log[$];
    logic [25:0] exp_wr[$];
    logic [1:0]  exp_st[$];

    always @(negedge clk) begin
        if (fbw_wren) begin
            wren_cnt <= wren_cnt + 1;
            wr_log.push_back({fbw_col_addr, fbw_data});
        end
        if (fbw_row_store != fbw_row_swap) pair_err <= pair_err + 1;
        if (fbw_row_store) begin
            store_cnt <= store_cnt + 1;
            st_log.push_back({fbw_bank_addr, fbw_row_addr});
        end
        if (frame_swap)  fswap_cnt  <= fswap_cnt + 1;
        if (stat_frame)  sframe_cnt <= sframe_cnt + 1;
        if (stat_resync) resync_cnt <= resync_cnt + 1;
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    function automatic logic [35:0] outs();
        return {in_ready, fbw_wren, fbw_col_addr, fbw_data, fbw_row_store, fbw_row_swap,
                fbw_bank_addr, fbw_row_addr, frame_swap, fb_loaded, stat_frame, stat_resync};
    endfunction

    function automatic logic [BD-1:0] pix(int f, int l, int c);
        return {8'(f), 8'(l), 8'(c)};
    endfunction

    task automatic clear_logs();
        wr_log.delete();
        st_log.delete();
        exp_wr.delete();
        exp_st.delete();
    endtask

    task automatic compare_logs(string tag);
        chk({tag, "_wr_count"}, 64'(wr_log.size()), 64'(exp_wr.size()));
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
            chk({tag, "_wr"}, 64'(wr_log[i]), 64'(exp_wr[i]));
        chk({tag, "_store_count"}, 64'(st_log.size()), 64'(exp_st.size()));
        for (int i = 0; i < st_log.size() && i < exp_st.size(); i++)
            chk({tag, "_store_bank_row"}, 64'(st_log[i]), 64'(exp_st[i]));
        clear_logs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        #1 chk("reset_async_outputs", 64'(outs()), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_outputs", 64'(outs()), 64'd0);
        rst = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    // Offer one pixel and hold it until accepted (bounded).
    task automatic push_px(logic [BD-1:0] d, logic sof, logic rr);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sof = sof; fbw_row_rdy = rr;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("push_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    // Send a full frame; optionally stall fbw_row_rdy for 20 cycles after line 'hold'.
    task automatic send_frame(int f, logic first_sof, int hold);
        int s_hold;
        logic any_rdy;
        for (int l = 0; l < LINES; l++) begin
            for (int c = 0; c < NC; c++) begin
                push_px(pix(f, l, c), first_sof && l == 0 && c == 0, !(l == hold && c == NC - 1));
                exp_wr.push_back({2'(c), pix(f, l, c)});
                if (c == NC - 1) exp_st.push_back(2'(l));
                if (l == hold && c == NC - 1) begin
                    s_hold  = store_cnt;
                    any_rdy = 1'b0;
                    repeat (20) begin
                        @(negedge clk);
                        in_valid = 1'b0;
                        if (in_ready) any_rdy = 1'b1;
                    end
                    chk("row_rdy_hold_in_ready", 64'(any_rdy), 64'd0);
                    chk("row_rdy_hold_no_store", 64'(store_cnt - s_hold), 64'd0);
                end
            end
        end
    endtask

    task automatic wait_frame_swap(int f0);
        int n;
        n = 0;
        while (fswap_cnt == f0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        idle(2);
    endtask

    typedef struct {
        logic          v;
        logic          s;
        logic [BD-1:0] d;
        logic          rr;
        logic          rdy;
        logic          wr;
        logic [1:0]    col;
        logic          st;
        logic          bank;
        logic          row;
        logic          rsy;
    } vec_t;

    vec_t tv[$];

    task automatic add(logic v, logic s, logic [BD-1:0] d, logic rr, logic rdy, logic wr,
                       logic [1:0] col, logic st, logic bank, logic row, logic rsy);
        vec_t t;
        t = '{v, s, d, rr, rdy, wr, col, st, bank, row, rsy};
        tv.push_back(t);
    endtask

    initial begin
        int w0, s0, f0, sf0, r0;
        logic any_rdy;

        //   v  s  data      rr rdy wr col st bk rw rsy
        add(0, 0, 24'h000000, 1, 0, 0, 0, 0, 0, 0, 0);  // first cycle out of reset
        add(1, 0, 24'h0000A0, 1, 1, 0, 0, 0, 0, 0, 0);  // before SOF: dropped
        add(1, 1, 24'h000010, 1, 1, 1, 0, 0, 0, 0, 0);  // SOF written at col 0
        add(1, 0, 24'h000011, 1, 1, 1, 1, 0, 0, 0, 0);
        add(1, 0, 24'h000012, 1, 1, 1, 2, 0, 0, 0, 0);
        add(1, 0, 24'h000013, 1, 1, 1, 3, 0, 0, 0, 0);  // last column -> ROW
        add(1, 0, 24'h000014, 1, 0, 0, 0, 1, 0, 0, 0);  // store line 0
        add(1, 0, 24'h000014, 1, 1, 1, 0, 0, 0, 0, 0);  // line 1 begins, pixel kept
        add(1, 0, 24'h000015, 1, 1, 1, 1, 0, 0, 0, 0);
        add(1, 1, 24'h000016, 1, 1, 1, 0, 0, 0, 0, 1);  // SOF at line 1 col 2 -> resync
        add(1, 0, 24'h000017, 1, 1, 1, 1, 0, 0, 0, 0);
        add(1, 0, 24'h000018, 1, 1, 1, 2, 0, 0, 0, 0);
        add(1, 0, 24'h000019, 1, 1, 1, 3, 0, 0, 0, 0);
        add(1, 0, 24'h00001A, 0, 0, 0, 0, 0, 0, 0, 0);  // row engine busy
        add(1, 0, 24'h00001A, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 24'h00001A, 1, 0, 0, 0, 1, 0, 0, 0);  // store bank 0 row 0 after resync
        add(1, 0, 24'h00001A, 1, 1, 1, 0, 0, 0, 0, 0);

        // Cycle-accurate vectors from reset.
        frame_rdy = 1'b1;
        do_reset();
        for (int i = 0; i < tv.size(); i++) begin
            in_valid = tv[i].v; in_sof = tv[i].s; in_data = tv[i].d; fbw_row_rdy = tv[i].rr;
            #1 chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tv[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_wren", i), 64'(fbw_wren), 64'(tv[i].wr));
            if (tv[i].wr) begin
                chk($sformatf("vec%0d_col", i), 64'(fbw_col_addr), 64'(tv[i].col));
                chk($sformatf("vec%0d_data", i), 64'(fbw_data), 64'(tv[i].d));
            end
            chk($sformatf("vec%0d_store", i), 64'(fbw_row_store), 64'(tv[i].st));
            chk($sformatf("vec%0d_row_swap", i), 64'(fbw_row_swap), 64'(tv[i].st));
            if (tv[i].st)
                chk($sformatf("vec%0d_bank_row", i), 64'({fbw_bank_addr, fbw_row_addr}),
                    64'({tv[i].bank, tv[i].row}));
            chk($sformatf("vec%0d_resync", i), 64'(stat_resync), 64'(tv[i].rsy));
            chk($sformatf("vec%0d_frame_swap", i), 64'(frame_swap), 64'd0);
            @(negedge clk);
        end

        // Full frame, then frame_rdy held low 50 cycles after the swap.
        do_reset();
        fbw_row_rdy = 1'b1;
        frame_rdy   = 1'b0;
        idle(1);
        clear_logs();
        w0 = wren_cnt; s0 = store_cnt; f0 = fswap_cnt; sf0 = sframe_cnt; r0 = resync_cnt;
        send_frame(1, 1'b1, -1);
        wait_frame_swap(f0);
        chk("frame1_wren_count", 64'(wren_cnt - w0), 64'(LINES * NC));
        chk("frame1_store_count", 64'(store_cnt - s0), 64'(LINES));
        chk("frame1_frame_swap", 64'(fswap_cnt - f0), 64'd1);
        chk("frame1_stat_frame", 64'(sframe_cnt - sf0), 64'd1);
        chk("frame1_no_resync", 64'(resync_cnt - r0), 64'd0);
        chk("frame1_fb_loaded", 64'(fb_loaded), 64'd1);
        compare_logs("frame1");

        w0 = wren_cnt;
        any_rdy = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (in_ready) any_rdy = 1'b1;
        end
        chk("swap_wait_in_ready", 64'(any_rdy), 64'd0);
        chk("swap_wait_no_wren", 64'(wren_cnt - w0), 64'd0);
        frame_rdy = 1'b1;

        // Second frame without SOF (line restarts at 0), row engine stalled after line 1.
        w0 = wren_cnt; s0 = store_cnt; f0 = fswap_cnt;
        send_frame(2, 1'b0, 1);
        wait_frame_swap(f0);
        chk("frame2_wren_count", 64'(wren_cnt - w0), 64'(LINES * NC));
        chk("frame2_store_count", 64'(store_cnt - s0), 64'(LINES));
        chk("frame2_frame_swap", 64'(fswap_cnt - f0), 64'd1);
        compare_logs("frame2");

        // Reset while waiting in ROW, then restart on SOF.
        for (int c = 0; c < NC; c++) push_px(pix(3, 0, c), 1'b0, 1'b0);
        idle(3);
        chk("loaded_before_rst", 64'(fb_loaded), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_mid_async_outputs", 64'(outs()), 64'd0);
        @(posedge clk);
        #1 chk("rst_mid_edge_outputs", 64'(outs()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        fbw_row_rdy = 1'b1;
        idle(1);
        clear_logs();
        w0 = wren_cnt; r0 = resync_cnt;
        push_px(pix(4, 0, 0), 1'b0, 1'b1);
        push_px(pix(4, 0, 1), 1'b0, 1'b1);
        idle(2);
        chk("pre_sof_dropped", 64'(wren_cnt - w0), 64'd0);
        for (int c = 0; c < NC; c++) begin
            push_px(pix(4, 7, c), c == 0, 1'b1);
            exp_wr.push_back({2'(c), pix(4, 7, c)});
        end
        exp_st.push_back(2'd0);
        idle(4);
        compare_logs("restart");
        chk("restart_no_resync", 64'(resync_cnt - r0), 64'd0);
        chk("restart_fb_loaded", 64'(fb_loaded), 64'd0);

        // SOF on the last pixel of line 1: resync wins, no row commit for line 1.
        clear_logs();
        r0 = resync_cnt; s0 = store_cnt; f0 = fswap_cnt;
        for (int c = 0; c < NC - 1; c++) begin
            push_px(pix(5, 1, c), 1'b0, 1'b1);
            exp_wr.push_back({2'(c), pix(5, 1, c)});
        end
        push_px(pix(5, 0, 0), 1'b1, 1'b1);
        exp_wr.push_back({2'd0, pix(5, 0, 0)});
        idle(3);
        chk("sof_last_no_store", 64'(store_cnt - s0), 64'd0);
        for (int c = 1; c < NC; c++) begin
            push_px(pix(5, 0, c), 1'b0, 1'b1);
            exp_wr.push_back({2'(c), pix(5, 0, c)});
        end
        exp_st.push_back(2'd0);
        idle(4);
        compare_logs("sof_last");
        chk("sof_last_resync", 64'(resync_cnt - r0), 64'd1);
        chk("sof_last_no_frame_swap", 64'(fswap_cnt - f0), 64'd0);

        chk("row_store_swap_pair", 64'(pair_err), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
